// File: rtl/hps_pixel_bridge.sv
// hps_pixel_bridge: turns HPS PIO pixel writes into range-checked commands held in a FWFT FIFO
// and replayed on a valid/ready plot port. Define CLEAR_FILL_EN to add the screen-fill engine.
module hps_pixel_bridge #(
   parameter int COLOUR_W   = 3,
   parameter int X_W        = 9,
   parameter int Y_W        = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                          CLOCK_50,
   input  logic                          reset_reset_n,
   input  logic [2+X_W+Y_W+COLOUR_W-1:0] pio_word,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic                          out_mode,
   output logic [X_W-1:0]                out_x,
   output logic [Y_W-1:0]                out_y,
   output logic [COLOUR_W-1:0]           out_colour,
   output logic                          writeEn,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]              ovf_cnt,
   output logic [CNT_W-1:0]              clip_cnt,
   output logic                          busy
`ifdef CLEAR_FILL_EN
   ,
   input  logic                          clear_req
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + X_W + Y_W + COLOUR_W;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                pio_wr;
   logic                pio_mode;
   logic [X_W-1:0]      pio_x;
   logic [Y_W-1:0]      pio_y;
   logic [COLOUR_W-1:0] pio_colour;

   assign pio_wr     = pio_word[0];
   assign pio_colour = pio_word[COLOUR_W:1];
   assign pio_y      = pio_word[COLOUR_W+Y_W:COLOUR_W+1];
   assign pio_x      = pio_word[COLOUR_W+Y_W+X_W:COLOUR_W+Y_W+1];
   assign pio_mode   = pio_word[EW];

   logic          wr_q;
   logic          cmd;
   logic          in_range;
   logic          full;
   logic          fifo_valid;
   logic          push;
   logic          pop;
   logic          filling;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] head;

   // Full-width compare so coordinate bits beyond the visible range still reject the command.
   assign in_range = pio_mode ? ((32'(pio_x) < 32'd320) && (32'(pio_y) < 32'd240))
                              : ((32'(pio_x) < 32'd160) && (32'(pio_y) < 32'd120));

   assign cmd        = pio_wr & ~wr_q;
   assign full       = (count == (AW+1)'(FIFO_DEPTH));
   assign fifo_valid = (count != '0);
   assign push       = cmd & in_range & ~full;
   assign pop        = fifo_valid & out_ready & ~filling;
   assign head       = mem[rd_ptr];
   assign fifo_count = count;

   // Stage p0: command capture and FIFO control
   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         wr_q     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf_cnt  <= '0;
         clip_cnt <= '0;
      end else begin
         wr_q <= pio_wr;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
         if (cmd && !in_range)
            clip_cnt <= sat_inc(clip_cnt);
         if (cmd && in_range && full)
            ovf_cnt <= sat_inc(ovf_cnt);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (push)
         mem[wr_ptr] <= {pio_mode, pio_x, pio_y, pio_colour};
   end

`ifdef CLEAR_FILL_EN
   typedef enum logic {IDLE, FILL} state_t;

   state_t              state;
   logic                clear_q;
   logic                fill_mode;
   logic [COLOUR_W-1:0] fill_colour;
   logic [X_W-1:0]      fx;
   logic [Y_W-1:0]      fy;
   logic [X_W-1:0]      last_x;
   logic [Y_W-1:0]      last_y;

   assign last_x  = fill_mode ? X_W'(319) : X_W'(159);
   assign last_y  = fill_mode ? Y_W'(239) : Y_W'(119);
   assign filling = (state == FILL);

   // Stage p0: fill sequencer, raster order, one pixel per accepted transfer
   always_ff @(posedge CLOCK_50) begin
      if (!reset_reset_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         clear_q     <= 1'b0;
         fill_mode   <= 1'b0;
         fill_colour <= '0;
         fx          <= '0;
         fy          <= '0;
      end else begin
         clear_q <= clear_req;
         case (state)
            IDLE: begin
               if (clear_req && !clear_q) begin
                  state       <= FILL;
                  busy        <= 1'b1;
                  fill_mode   <= pio_mode;
                  fill_colour <= pio_colour;
                  fx          <= '0;
                  fy          <= '0;
               end
            end
            FILL: begin
               if (out_ready) begin
                  if (fx == last_x) begin
                     fx <= '0;
                     if (fy == last_y) begin
                        fy    <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        fy <= fy + 1'b1;
                     end
                  end else begin
                     fx <= fx + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
`else
   assign filling = 1'b0;
   assign busy    = 1'b0;
`endif

   // Fields are forced to zero when nothing is presented so reset leaves every output low.
   always_comb begin
      out_valid  = fifo_valid;
      out_mode   = 1'b0;
      out_x      = '0;
      out_y      = '0;
      out_colour = '0;
      if (fifo_valid)
         {out_mode, out_x, out_y, out_colour} = head;
`ifdef CLEAR_FILL_EN
      if (filling) begin
         out_valid  = 1'b1;
         out_mode   = fill_mode;
         out_x      = fx;
         out_y      = fy;
         out_colour = fill_colour;
      end
`endif
   end

   assign writeEn = out_valid & out_ready;

endmodule

// File: tb/tb_hps_pixel_bridge.sv
// Randomised bench for hps_pixel_bridge: a queue-based pixel model predicts every output each cycle.
module tb_hps_pixel_bridge;
   localparam int COLOUR_W   = 3;
   localparam int X_W        = 9;
   localparam int Y_W        = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 16;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [2+X_W+Y_W+COLOUR_W-1:0] pio_word;
   logic                          out_ready;
   logic                          out_valid;
   logic                          out_mode;
   logic [X_W-1:0]                out_x;
   logic [Y_W-1:0]                out_y;
   logic [COLOUR_W-1:0]           out_colour;
   logic                          writeEn;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic [CNT_W-1:0]              ovf_cnt;
   logic [CNT_W-1:0]              clip_cnt;
   logic                          busy;
`ifdef CLEAR_FILL_EN
   logic                          clear_req;
   bit                            clr_prev;
`endif

   always #5 clk = ~clk;

   hps_pixel_bridge #(
      .COLOUR_W(COLOUR_W), .X_W(X_W), .Y_W(Y_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .CLOCK_50(clk),
      .reset_reset_n(rst_n),
      .pio_word(pio_word),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_mode(out_mode),
      .out_x(out_x),
      .out_y(out_y),
      .out_colour(out_colour),
      .writeEn(writeEn),
      .fifo_count(fifo_count),
      .ovf_cnt(ovf_cnt),
      .clip_cnt(clip_cnt),
      .busy(busy)
`ifdef CLEAR_FILL_EN
      ,
      .clear_req(clear_req)
`endif
   );

   typedef struct packed {
      logic                mode;
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] c;
   } pix_t;

   pix_t                q[$];
   int                  ovf_m, clip_m;
   bit                  wr_prev;
   bit                  fill_on, fmode;
   int                  fx, fy;
   logic [COLOUR_W-1:0] fcol;
   bit                  cur_m, cur_wr;
   int                  cur_x, cur_y, cur_c;
   bit                  pv_valid, pv_ready;
   pix_t                pv;
   int                  n_checks, n_errors, n_xfer, n0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_pio(input bit m, input int x, input int y, input int c, input bit wr);
      cur_m = m; cur_x = x; cur_y = y; cur_c = c; cur_wr = wr;
      pio_word = {m, X_W'(x), Y_W'(y), COLOUR_W'(c), wr};
   endtask

   // Reference behaviour applied at each rising edge, from the values driven during the cycle.
   task automatic model_step();
      bit   cmd, ok, was_full, do_pop, do_push;
      int   w, h;
      pix_t p;
      cmd      = cur_wr && !wr_prev;
      was_full = (q.size() == FIFO_DEPTH);
      do_pop   = (q.size() != 0) && out_ready && !fill_on;
      do_push  = 1'b0;
      p        = '0;
      if (cmd) begin
         ok = cur_m ? (cur_x < 320 && cur_y < 240) : (cur_x < 160 && cur_y < 120);
         if (!ok) clip_m++;
         else if (was_full) ovf_m++;
         else begin
            do_push = 1'b1;
            p.mode = cur_m; p.x = X_W'(cur_x); p.y = Y_W'(cur_y); p.c = COLOUR_W'(cur_c);
         end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(p);
      if (fill_on) begin
         w = fmode ? 320 : 160;
         h = fmode ? 240 : 120;
         if (out_ready) begin
            if (fx == w - 1) begin
               fx = 0;
               if (fy == h - 1) fill_on = 1'b0;
               else fy++;
            end else fx++;
         end
      end
`ifdef CLEAR_FILL_EN
      else if (clear_req && !clr_prev) begin
         fill_on = 1'b1; fmode = cur_m; fcol = COLOUR_W'(cur_c); fx = 0; fy = 0;
      end
      clr_prev = clear_req;
`endif
      wr_prev = cur_wr;
   endtask

   task automatic cycle();
      bit   ev;
      pix_t h;
      #4;
      ev = fill_on || (q.size() != 0);
      h  = '0;
      if (fill_on) begin
         h.mode = fmode; h.x = X_W'(fx); h.y = Y_W'(fy); h.c = fcol;
      end else if (q.size() != 0) h = q[0];
      if (pv_valid && !pv_ready) begin
         check("stall_valid", out_valid, 1);
         check("stall_hold", {out_mode, out_x, out_y, out_colour}, pv);
      end
      check("valid", out_valid, ev);
      if (ev) check("pixel", {out_mode, out_x, out_y, out_colour}, h);
      check("wen", writeEn, ev && out_ready);
      check("count", fifo_count, q.size());
      check("ovf", ovf_cnt, ovf_m);
      check("clip", clip_cnt, clip_m);
      check("busy", busy, fill_on);
      if (writeEn === 1'b1) n_xfer++;
      pv_valid = (out_valid === 1'b1);
      pv_ready = out_ready;
      pv       = {out_mode, out_x, out_y, out_colour};
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic issue(input bit m, input int x, input int y, input int c);
      set_pio(m, x, y, c, 1'b1);
      cycle();
      set_pio(m, x, y, c, 1'b0);
      cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_pio(0, 0, 0, 0, 0);
`ifdef CLEAR_FILL_EN
      clear_req = 1'b0;
      clr_prev  = 1'b0;
`endif
      @(posedge clk); #1;
      @(posedge clk); #1;
      q.delete();
      ovf_m = 0; clip_m = 0; wr_prev = 0; fill_on = 0; fx = 0; fy = 0; pv_valid = 0;
      check("rst_valid", out_valid, 0);
      check("rst_wen", writeEn, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", ovf_cnt, 0);
      check("rst_clip", clip_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_fields", {out_mode, out_x, out_y, out_colour}, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; n_xfer = 0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      set_pio(0, 0, 0, 0, 0);
`ifdef CLEAR_FILL_EN
      clear_req = 1'b0;
`endif
      #1;
      do_reset();

      // Single command: visible one cycle after the wr edge, for one cycle.
      set_pio(0, 5, 7, 3, 1);
      cycle();
      set_pio(0, 5, 7, 3, 0);
      #1;
      check("t1_valid", out_valid, 1);
      check("t1_pix", {out_x, out_y, out_colour}, {9'd5, 8'd7, 3'd3});
      n0 = n_xfer;
      for (int i = 0; i < 4; i++) cycle();
      check("t1_xfers", n_xfer - n0, 1);

      // Held wr yields one command; eight toggles yield eight.
      n0 = n_xfer;
      set_pio(0, 20, 30, 6, 1);
      for (int i = 0; i < 10; i++) cycle();
      set_pio(0, 20, 30, 6, 0);
      for (int i = 0; i < 3; i++) cycle();
      check("t2_held", n_xfer - n0, 1);
      n0 = n_xfer;
      for (int i = 0; i < 8; i++) issue(0, i * 3, i + 1, i);
      for (int i = 0; i < 3; i++) cycle();
      check("t2_toggle", n_xfer - n0, 8);

      // Range limits per mode.
      issue(0, 160, 0, 1);
      check("t3_clip", clip_cnt, 1);
      n0 = n_xfer;
      issue(1, 200, 239, 5);
      cycle();
      check("t3_mode1", n_xfer - n0, 1);
      issue(0, 0, 120, 2);
      issue(1, 320, 0, 2);
      issue(0, 159, 119, 4);
      cycle();
      check("t3_clip3", clip_cnt, 3);

      // Overflow with the output stalled, then a full-rate drain.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) issue(0, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
      check("t4_count", fifo_count, 16);
      check("t4_ovf", ovf_cnt, 4);
      out_ready = 1'b1;
      n0 = n_xfer;
      for (int i = 0; i < 16; i++) cycle();
      check("t4_drain", n_xfer - n0, 16);
      check("t4_empty", fifo_count, 0);

      // Random back-pressure during a burst.
      do_reset();
      n0 = n_xfer;
      for (int i = 0; i < 16; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         set_pio(1'($urandom_range(0, 1)), $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1);
         cycle();
         out_ready = 1'($urandom_range(0, 1));
         cur_wr = 1'b0; pio_word[0] = 1'b0;
         cycle();
      end
      for (int i = 0; i < 200 && q.size() != 0; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      check("t5_empty", fifo_count, 0);
      check("t5_xfers", n_xfer - n0, 16);

      // Fully random traffic including clipped coordinates.
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         set_pio(1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, 255),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)));
         cycle();
      end

`ifdef CLEAR_FILL_EN
      // Fill in raster order with FIFO commands queued behind it.
      do_reset();
      out_ready = 1'b1;
      set_pio(0, 0, 0, 2, 0);
      clear_req = 1'b1;
      n0 = n_xfer;
      cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 100; i++) cycle();
      issue(0, 10, 11, 5);
      issue(0, 12, 13, 6);
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 20000 && (fill_on || q.size() != 0); i++) cycle();
      check("t6_done", busy, 0);
      check("t6_xfers", n_xfer - n0, 19202);
      set_pio(1, 0, 0, 7, 0);
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 50; i++) cycle();
      issue(0, 1, 1, 1);
      check("t6_busy", busy, 1);
      do_reset();
      cycle();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
